wb_arb_rr: RTL and testbench



---
 rtl/wb_arb_rr_if.sv | 61 ++++++
 rtl/wb_arb_rr.sv | 176 +++++++++++++++++
 tb/tb_wb_arb_rr.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arb_rr_if.sv
// ---------------------------------------------------------------------------
// wb_arb_rr_if
//   Signal bundle for the wb_arb_rr Wishbone arbiter: the MASTER_COUNT
//   upstream master ports (packed, master k in slice k), the single
//   downstream port, and the grant / watchdog status outputs.
//
//   Modports
//     slave  : arbiter view. It is the slave of the upstream masters, and it
//              drives the downstream port and the status outputs.
//     master : environment view. It drives the master requests and the
//              downstream slave responses.
// ---------------------------------------------------------------------------
interface wb_arb_rr_if #(
    parameter int MASTER_COUNT = 4
);
    // upstream masters
    logic [MASTER_COUNT-1:0]    m_cyc_i;
    logic [MASTER_COUNT-1:0]    m_stb_i;
    logic [MASTER_COUNT*30-1:0] m_addr_i;
    logic [MASTER_COUNT*3-1:0]  m_cti_i;
    logic [MASTER_COUNT*2-1:0]  m_bte_i;
    logic [MASTER_COUNT*4-1:0]  m_sel_i;
    logic [MASTER_COUNT-1:0]    m_we_i;
    logic [MASTER_COUNT*32-1:0] m_data_i;
    logic [31:0]                m_data_o;
    logic [MASTER_COUNT-1:0]    m_ack_o;
    logic [MASTER_COUNT-1:0]    m_err_o;

    // downstream port
    logic                       s_cyc_o;
    logic                       s_stb_o;
    logic                       s_we_o;
    logic [29:0]                s_addr_o;
    logic [2:0]                 s_cti_o;
    logic [1:0]                 s_bte_o;
    logic [3:0]                 s_sel_o;
    logic [31:0]                s_data_o;
    logic [31:0]                s_data_i;
    logic                       s_ack_i;
    logic                       s_err_i;

    // status
    logic [MASTER_COUNT-1:0]    grant_o;
    logic                       timeout_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_addr_i, m_cti_i, m_bte_i, m_sel_i, m_we_i, m_data_i,
        input  s_data_i, s_ack_i, s_err_i,
        output m_data_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o, s_data_o,
        output grant_o, timeout_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_addr_i, m_cti_i, m_bte_i, m_sel_i, m_we_i, m_data_i,
        output s_data_i, s_ack_i, s_err_i,
        input  m_data_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_cti_o, s_bte_o, s_sel_o, s_data_o,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/wb_arb_rr.sv
// ---------------------------------------------------------------------------
// wb_arb_rr
//   Wishbone arbiter: MASTER_COUNT masters share one downstream port.
//   Fixed priority (RR_MODE=0, lowest index wins) or round-robin (RR_MODE=1,
//   search starts after the last winner). A granted cycle is never
//   pre-empted; it ends when the owner drops cyc. A watchdog aborts a strobe
//   left unanswered for TIMEOUT cycles (0 disables it) by returning err to
//   the owner and isolating the slave until the owner releases the bus.
//
//   Ports
//     wb_clk : clock, all logic on the rising edge
//     wb_rst : synchronous active-high reset
//     bus    : wb_arb_rr_if.slave (master ports, downstream port,
//              grant_o one-hot owner, timeout_o one-cycle abort pulse)
// ---------------------------------------------------------------------------
module wb_arb_rr #(
    parameter int MASTER_COUNT = 4,
    parameter int RR_MODE      = 1,
    parameter int TIMEOUT      = 1023
) (
    input  logic         wb_clk,
    input  logic         wb_rst,
    wb_arb_rr_if.slave   bus
);
    localparam int IW   = $clog2(MASTER_COUNT);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        ABORT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [MASTER_COUNT-1:0] grant_q, grant_d;
    logic [IW-1:0]           owner_q, owner_d;   // binary index of grant_q
    logic [IW-1:0]           last_q, last_d;     // round-robin pointer
    logic [WD_W-1:0]         wd_q, wd_d;

    logic [IW-1:0]           winner;
    logic [IW:0]             cand;
    logic                    found;
    logic                    owner_cyc;
    logic                    live;
    logic                    stall;
    logic                    wd_fire;

    // Arbitration. In round-robin mode the candidate walks last+1, last+2, ...
    // modulo MASTER_COUNT; the sum never reaches 2*MASTER_COUNT, so a single
    // conditional subtraction is enough for any master count.
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values computed above them; registers are written with '<=' only.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (RR_MODE != 0) begin
                cand = {1'b0, last_q} + (IW+1)'(i + 1);
                if (cand >= (IW+1)'(MASTER_COUNT)) begin
                    cand = cand - (IW+1)'(MASTER_COUNT);
                end
            end else begin
                cand = (IW+1)'(i);
            end
            if (!found && bus.m_cyc_i[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    // The downstream port is live only while the owner still holds cyc, so
    // the release cycle already presents an idle bus.
    assign owner_cyc = bus.m_cyc_i[owner_q];
    assign live      = (state_q == BUS) && owner_cyc;
    assign stall     = live && bus.m_stb_i[owner_q] && !bus.s_ack_i && !bus.s_err_i;
    assign wd_fire   = (TIMEOUT > 0) && stall && (wd_q == WD_W'(TIMEOUT - 1));

    // Datapath mux and response steering.
    // NOTE: every output is given a default before any branch, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        bus.s_cyc_o   = 1'b0;
        bus.s_stb_o   = 1'b0;
        bus.s_we_o    = 1'b0;
        bus.s_addr_o  = '0;
        bus.s_cti_o   = '0;
        bus.s_bte_o   = '0;
        bus.s_sel_o   = '0;
        bus.s_data_o  = '0;
        bus.m_data_o  = '0;
        bus.m_ack_o   = '0;
        bus.m_err_o   = '0;
        bus.timeout_o = 1'b0;
        if (live) begin
            bus.s_cyc_o  = 1'b1;
            bus.s_stb_o  = bus.m_stb_i[owner_q];
            bus.s_we_o   = bus.m_we_i[owner_q];
            bus.s_addr_o = bus.m_addr_i[int'(owner_q)*30 +: 30];
            bus.s_cti_o  = bus.m_cti_i[int'(owner_q)*3 +: 3];
            bus.s_bte_o  = bus.m_bte_i[int'(owner_q)*2 +: 2];
            bus.s_sel_o  = bus.m_sel_i[int'(owner_q)*4 +: 4];
            bus.s_data_o = bus.m_data_i[int'(owner_q)*32 +: 32];
            bus.m_data_o = bus.s_data_i;
            bus.m_ack_o  = grant_q & {MASTER_COUNT{bus.s_ack_i}};
            bus.m_err_o  = grant_q & {MASTER_COUNT{bus.s_err_i}};
        end
        if (state_q == ABORT) begin
            bus.m_err_o   = grant_q;
            bus.timeout_o = 1'b1;
        end
    end

    assign bus.grant_o = grant_q;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        wd_d    = '0;
        if (stall && !wd_fire && (TIMEOUT > 0)) begin
            wd_d = wd_q + WD_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = BUS;
                    grant_d = MASTER_COUNT'(1) << winner;
                    owner_d = winner;
                    last_d  = winner;
                end
            end
            BUS: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (wd_fire) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(MASTER_COUNT - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_wb_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_wb_arb_rr
//   Three arbiters with four masters share one stimulus:
//     gen_dut[0] round-robin, TIMEOUT=8  (main subject)
//     gen_dut[1] fixed priority, TIMEOUT=8
//     gen_dut[2] round-robin, TIMEOUT=0  (watchdog disabled)
//   Each cycle record carries the inputs and the expected outputs of
//   gen_dut[0]; it is queued when driven and popped when the outputs are
//   sampled mid-cycle. Master k always presents fixed attributes, so the
//   expected downstream values follow from the expected grant.
// ---------------------------------------------------------------------------
module tb_wb_arb_rr;
    localparam int N = 4;

    typedef struct {
        logic        rst;
        logic [3:0]  cyc;      // m_cyc_i, m_stb_i follows it
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  grant;    // expected grant_o
        logic        scyc;     // expected s_cyc_o
        logic [3:0]  err_exp;  // expected m_err_o
        logic        to;       // expected timeout_o
        logic        fp_chk;   // compare the fixed-priority instance too
        logic [3:0]  fp_grant;
    } vec_t;

    logic              wb_clk = 1'b0;
    logic              wb_rst;
    logic [N-1:0]      m_cyc;
    logic [N-1:0]      m_stb;
    logic [N*30-1:0]   m_addr;
    logic [N*3-1:0]    m_cti;
    logic [N*2-1:0]    m_bte;
    logic [N*4-1:0]    m_sel;
    logic [N-1:0]      m_we;
    logic [N*32-1:0]   m_wdata;
    logic [31:0]       s_data;
    logic              s_ack;
    logic              s_err;

    int total = 0;
    int bad   = 0;
    int vnum  = 0;
    vec_t sb[$];
    vec_t tbl[$];

    always #5 wb_clk = ~wb_clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        wb_arb_rr_if #(.MASTER_COUNT(N)) bus_if ();
        assign bus_if.m_cyc_i  = m_cyc;
        assign bus_if.m_stb_i  = m_stb;
        assign bus_if.m_addr_i = m_addr;
        assign bus_if.m_cti_i  = m_cti;
        assign bus_if.m_bte_i  = m_bte;
        assign bus_if.m_sel_i  = m_sel;
        assign bus_if.m_we_i   = m_we;
        assign bus_if.m_data_i = m_wdata;
        assign bus_if.s_data_i = s_data;
        assign bus_if.s_ack_i  = s_ack;
        assign bus_if.s_err_i  = s_err;
        wb_arb_rr #(
            .MASTER_COUNT(N),
            .RR_MODE     ((g == 1) ? 0 : 1),
            .TIMEOUT     ((g == 2) ? 0 : 8)
        ) dut (
            .wb_clk (wb_clk),
            .wb_rst (wb_rst),
            .bus    (bus_if)
        );
    end

    // Fixed per-master attributes.
    function automatic logic [29:0] addr_of(int k);
        return 30'(32'h0012_3400 + k);
    endfunction
    function automatic logic [31:0] wdata_of(int k);
        return 32'hA5A5_0000 + 32'(k);
    endfunction

    function automatic vec_t mk(logic rst, logic [3:0] cyc, logic ack, logic err,
                                logic [31:0] rd, logic [3:0] g, logic sc,
                                logic [3:0] ee, logic to, logic fc, logic [3:0] fg);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.err = err; v.rdata = rd;
        v.grant = g; v.scyc = sc; v.err_exp = ee; v.to = to;
        v.fp_chk = fc; v.fp_grant = fg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL v%0d %s: got %h expected %h", vnum, name, act, exp);
        end
    endtask

    task automatic compare(input vec_t e);
        int   k;
        logic l;
        k = 0;
        for (int i = 0; i < N; i++) if (e.grant[i]) k = i;
        l = e.scyc;
        check("grant_o",   32'(gen_dut[0].bus_if.grant_o),   32'(e.grant));
        check("s_cyc_o",   32'(gen_dut[0].bus_if.s_cyc_o),   32'(e.scyc));
        check("s_stb_o",   32'(gen_dut[0].bus_if.s_stb_o),   32'(l));
        check("s_addr_o",  32'(gen_dut[0].bus_if.s_addr_o),  l ? 32'(addr_of(k)) : 32'd0);
        check("s_cti_o",   32'(gen_dut[0].bus_if.s_cti_o),   l ? 32'(k) : 32'd0);
        check("s_bte_o",   32'(gen_dut[0].bus_if.s_bte_o),   l ? 32'(k % 4) : 32'd0);
        check("s_sel_o",   32'(gen_dut[0].bus_if.s_sel_o),   l ? 32'(1 << k) : 32'd0);
        check("s_we_o",    32'(gen_dut[0].bus_if.s_we_o),    (l && k == 1) ? 32'd1 : 32'd0);
        check("s_data_o",  gen_dut[0].bus_if.s_data_o,       l ? wdata_of(k) : 32'd0);
        check("m_data_o",  gen_dut[0].bus_if.m_data_o,       l ? e.rdata : 32'd0);
        check("m_ack_o",   32'(gen_dut[0].bus_if.m_ack_o),   (l && e.ack) ? 32'(e.grant) : 32'd0);
        check("m_err_o",   32'(gen_dut[0].bus_if.m_err_o),   32'(e.err_exp));
        check("timeout_o", 32'(gen_dut[0].bus_if.timeout_o), 32'(e.to));
        check("t0 grant_o",   32'(gen_dut[2].bus_if.grant_o),   32'(e.grant));
        check("t0 timeout_o", 32'(gen_dut[2].bus_if.timeout_o), 32'd0);
        if (e.fp_chk) begin
            check("fp grant_o", 32'(gen_dut[1].bus_if.grant_o), 32'(e.fp_grant));
        end
    endtask

    // Drive one cycle just after the rising edge, sample at the falling edge.
    task automatic apply(input vec_t v);
        @(posedge wb_clk);
        #1;
        wb_rst = v.rst;
        m_cyc  = v.cyc;
        m_stb  = v.cyc;
        s_ack  = v.ack;
        s_err  = v.err;
        s_data = v.rdata;
        sb.push_back(v);
        #4;
        vnum++;
        compare(sb.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL sim_limit: time bound reached, got no finish expected finish");
        $fatal(1, "simulation time bound reached");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            m_addr[30*k +: 30] = addr_of(k);
            m_cti[3*k +: 3]    = 3'(k);
            m_bte[2*k +: 2]    = 2'(k % 4);
            m_sel[4*k +: 4]    = 4'(1 << k);
            m_we[k]            = (k == 1);
            m_wdata[32*k +: 32] = wdata_of(k);
        end
        wb_rst = 1'b1; m_cyc = 4'hF; m_stb = 4'hF;
        s_ack = 1'b0; s_err = 1'b0; s_data = '0;
        repeat (2) @(posedge wb_clk);

        // Reset with all masters requesting, then single transfers from all
        // masters: round-robin visits 0,1,2,3,0; fixed priority keeps 0.
        //             rst cyc   ack err rdata          grant  sc err  to fc fp
        tbl.push_back(mk(1, 4'hF, 0, 0, 32'hC0DE_0000, 4'h0, 0, 4'h0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hC0DE_0001, 4'h0, 0, 4'h0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hC0DE_0002, 4'h1, 1, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 32'hC0DE_0003, 4'h1, 1, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hE, 0, 0, 32'hC0DE_0004, 4'h1, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hC0DE_0005, 4'h0, 0, 4'h0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 4'hF, 1, 0, 32'hC0DE_0006, 4'h2, 1, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hD, 0, 0, 32'hC0DE_0007, 4'h2, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hC0DE_0008, 4'h0, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 32'hC0DE_0009, 4'h4, 1, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hB, 0, 0, 32'hC0DE_000A, 4'h4, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hC0DE_000B, 4'h0, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 32'hC0DE_000C, 4'h8, 1, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'h7, 0, 0, 32'hC0DE_000D, 4'h8, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 0, 0, 32'hC0DE_000E, 4'h0, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'hF, 1, 0, 32'hC0DE_000F, 4'h1, 1, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 32'hC0DE_0010, 4'h1, 0, 4'h0, 0, 1, 4'h1));
        tbl.push_back(mk(0, 4'h0, 0, 0, 32'hC0DE_0011, 4'h0, 0, 4'h0, 0, 1, 4'h0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Master 2 four-beat burst while master 0 waits.
        apply(mk(0, 4'b0100, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        for (int b = 0; b < 4; b++)
            apply(mk(0, 4'b0101, 1, 0, 32'hB000_0000 + 32'(b), 4'h4, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0001, 0, 0, 32'h0, 4'h4, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0001, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0001, 1, 0, 32'h1234_5678, 4'h1, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h1, 0, 4'h0, 0, 0, 4'h0));

        // Watchdog: master 1 is never answered; late ack in DRAIN is dropped.
        apply(mk(0, 4'b0010, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        for (int c = 0; c < 8; c++)
            apply(mk(0, 4'b0010, 0, 0, 32'h5555_0000 + 32'(c), 4'h2, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0010, 0, 0, 32'h0, 4'h2, 0, 4'h2, 1, 0, 4'h0));
        apply(mk(0, 4'b0010, 1, 0, 32'h6666_6666, 4'h2, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h2, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0001, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0001, 1, 0, 32'h7777_0001, 4'h1, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h1, 0, 4'h0, 0, 0, 4'h0));

        // Read data returned to master 3 only.
        apply(mk(0, 4'b1000, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b1000, 1, 0, 32'hDEAD_BEEF, 4'h8, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h8, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));

        // Reset mid-burst: next cycle is IDLE and the pointer is back at 3,
        // so with masters 1 and 2 requesting, master 1 wins.
        apply(mk(0, 4'b0010, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0010, 1, 0, 32'h8888_0001, 4'h2, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(1, 4'b0010, 1, 0, 32'h8888_0002, 4'h2, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0110, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0110, 1, 0, 32'h8888_0003, 4'h2, 1, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0100, 0, 0, 32'h0, 4'h2, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0100, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0100, 0, 1, 32'h9999_0000, 4'h4, 1, 4'h4, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h4, 0, 4'h0, 0, 0, 4'h0));
        apply(mk(0, 4'b0000, 0, 0, 32'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
